// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: operation modes and FSM states.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_LSR  = 3'b000,
    MODE_LSL  = 3'b001,
    MODE_ASR  = 3'b010,
    MODE_ASL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_PASS = 3'b110
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Both 110 and 111 mean pass-through.
  function automatic logic mode_is_pass(input logic [MODE_W-1:0] mode);
    return mode[2] & mode[1];
  endfunction

endpackage

// File: rtl/shift_step_8b.sv
// One single-bit shift/rotate step: next data, bit shifted out, and ASL sign-change flag.
module shift_step_8b
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] data_o,
  output logic             carry_o,
  output logic             ovf_o
);

  always_comb begin
    data_o  = data_i;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (mode_i)
      MODE_LSR: begin
        data_o  = {1'b0, data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      MODE_LSL: begin
        data_o  = {data_i[WIDTH-2:0], 1'b0};
        carry_o = data_i[WIDTH-1];
      end
      MODE_ASR: begin
        data_o  = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      MODE_ASL: begin
        data_o  = {data_i[WIDTH-2:0], 1'b0};
        carry_o = data_i[WIDTH-1];
        // Sign flips when the two top bits differ before the step.
        ovf_o   = data_i[WIDTH-1] ^ data_i[WIDTH-2];
      end
      MODE_ROR: begin
        data_o  = {data_i[0], data_i[WIDTH-1:1]};
        carry_o = data_i[0];
      end
      MODE_ROL: begin
        data_o  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        carry_o = data_i[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer_8b.sv
// Multi-cycle shifter: accepts one command, applies one bit step per cycle, holds result until taken.
module shift_sequencer_8b
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  mode_e            mode_q,  mode_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic             ovf_q,   ovf_d;

  logic [WIDTH-1:0] step_data;
  logic             step_carry;
  logic             step_ovf;

  shift_step_8b #(.WIDTH(WIDTH)) u_step (
    .data_i  (data_q),
    .mode_i  (mode_q),
    .data_o  (step_data),
    .carry_o (step_carry),
    .ovf_o   (step_ovf)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      mode_q  <= MODE_PASS;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = mode_e'(in_mode);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if ((in_amt != '0) && !mode_is_pass(in_mode)) begin
            cnt_d   = in_amt;
            state_d = ST_SHIFT;
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        ovf_d   = ovf_q | step_ovf;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = ~|data_q;

endmodule
